pipelined_rca_addsub: RTL and testbench
=======================================

// Module: pipelined_rca_addsub
// PURPOSE
//   Parametrised, pipelined ripple-carry adder/subtractor for the datapath adder family.
//   Splits a WIDTH-bit add into STAGES equal chunks, one chunk per clock, so the carry chain is registered between chunks.
//   Adds add/sub mode, a signed-overflow flag and valid/ready flow control at both ends.
//   Fixed-width 16/32-bit ripple adders have none of these; this block sits between operand registers and the ALU result mux.
// PARAMETERS
//   WIDTH   32  operand/result width in bits; must be a multiple of STAGES
//   STAGES  4   pipeline depth = number of carry chunks; CHUNK = WIDTH/STAGES; STAGES >= 1
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operand set present on a/b/c_in/sub
//   in_ready   out  1      block accepts operands this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   c_in       in   1      carry-in (add) / borrow-in (sub)
//   sub        in   1      0 = add, 1 = subtract
//   out_valid  out  1      s/c_out/ovf hold a valid result
//   out_ready  in   1      downstream accepts the result this cycle
//   s          out  WIDTH  sum/difference
//   c_out      out  1      carry out of bit WIDTH-1 (sub: 1 = no borrow)
//   ovf        out  1      signed overflow
// BEHAVIOUR
//   Arithmetic: b_eff = sub ? ~b : b; cin_eff = c_in ^ sub.
//     {c_out,s} = a + b_eff + cin_eff, computed modulo 2^WIDTH.
//     ovf = carry into bit WIDTH-1 XOR c_out.
//     sub=1, c_in=1 gives a-b-1.
//   Pipeline: stage k register (k = 0..STAGES-1) holds:
//     - result bits [(k+1)*CHUNK-1:0]
//     - carry out of chunk k
//     - unprocessed upper bits of a and b_eff
//     - a valid bit
//     - carry into the top bit, valid only in the last stage
//   Stage 0 computes chunk 0 directly from the inputs. Stage k computes chunk k from stage k-1.
//   Flow control: global advance adv = ~out_valid | out_ready; in_ready = adv & ~rst.
//     - When adv=1, every stage shifts by one. Stage 0 loads (in_valid & in_ready).
//     - When adv=0, all stages hold. Bubbles are not compressed.
//   Transfers: an input transfer is in_valid & in_ready; an output transfer is out_valid & out_ready.
//   Latency: operands accepted in cycle n appear on the outputs in cycle n+STAGES (no stall). Throughput is 1 per cycle.
//   Outputs come from last-stage registers, with no combinational path from a/b to s.
//   While out_valid & ~out_ready, s/c_out/ovf are held stable.
//   Order is strictly FIFO. No transaction is lost or duplicated under any stall pattern.
//   Reset (rst=1 at a clock edge):
//     - clears all valid bits and data registers, including mid-operation; in-flight results are discarded.
//     - outputs in the next cycle: out_valid=0, s=0, c_out=0, ovf=0.
//     - in_ready=0 while rst is high and 1 in the first cycle after release.
//   Simultaneous output transfer and input transfer in the same cycle is legal, and full throughput is sustained.
//   STAGES=1 degenerates to a single registered WIDTH-bit adder with latency 1.
//   Reject STAGES=0 or WIDTH % STAGES != 0 at elaboration via a generate-time error.
// STRUCTURE
//   Shared include adder_defs.vh holds:
//     - default WIDTH/STAGES
//     - the CHUNK derivation macro
//     - the elaboration check macro
//   Sub-module rca_chunk: combinational CHUNK-bit ripple adder (a, b, cin -> s, cout, c_msb), where c_msb is the carry into the top bit.
//     Instantiate it once per stage in a generate loop.
//   Pipeline registers and flow control live in this module.
// TESTING (WIDTH=32, STAGES=4 unless noted; out_ready=1 unless noted)
//   1. Hold rst for 3 cycles, then release -> out_valid=0, s=0, in_ready=1 in the first cycle after release.
//   2. a=FFFFFFFF, b=00000001, c_in=0, sub=0 -> 4 cycles later s=00000000, c_out=1, ovf=0.
//   3. a=7FFFFFFF, b=00000001, sub=0 -> s=80000000, c_out=0, ovf=1; same with c_in=1 -> s=80000001.
//   4. a=00000005, b=00000007, sub=1, c_in=0 -> s=FFFFFFFE, c_out=0, ovf=0; with c_in=1 -> s=FFFFFFFD.
//   5. Run 8 back-to-back random ops with out_ready=0 for cycles 3-7:
//      - results match the golden model, in order, with none lost;
//      - outputs stay stable while stalled;
//      - in_ready=0 whenever out_valid & ~out_ready.
//   6. Assert rst for 1 cycle with 3 ops in flight -> next cycle out_valid=0; no stale result ever appears.
//   7. WIDTH=8, STAGES=1: a=80, b=80 -> s=00, c_out=1, ovf=1, latency 1 cycle.

Source files
------------

// File: rtl/pipelined_rca_addsub_pkg.sv
// Shared configuration for the pipelined ripple-carry adder/subtractor.
//   DefWidth / DefStages : default operand width and pipeline depth
//   chunk_width()        : bits handled by each pipeline stage
//   cfg_ok()             : legality of a WIDTH/STAGES pair
package pipelined_rca_addsub_pkg;

    localparam int unsigned DefWidth  = 32;
    localparam int unsigned DefStages = 4;

    // Guard against divide-by-zero so an illegal STAGES still elaborates far enough
    // to report the configuration error.
    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

    function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
        return (stages >= 1) && (width % stages == 0) && (width >= stages);
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational ripple-carry adder for one pipeline chunk.
//   a_i, b_i   : chunk operands
//   cin_i      : carry into bit 0
//   s_o        : chunk sum
//   cout_o     : carry out of the top bit
//   c_msb_o    : carry into the top bit (used for signed overflow)
module rca_chunk #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] s_o,
    output logic         cout_o,
    output logic         c_msb_o
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        s_o  = '0;
        c[0] = cin_i;
        for (int i = 0; i < int'(W); i++) begin
            s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o  = c[W];
    assign c_msb_o = c[W-1];

endmodule

// File: rtl/pipelined_rca_addsub.sv
// Pipelined ripple-carry adder/subtractor with valid/ready flow control.
// One CHUNK = WIDTH/STAGES slice of the carry chain is resolved per stage; the
// carry is registered between slices. Results leave from last-stage registers.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, c_in, sub)
//   out_valid/out_ready : result handshake (s, c_out, ovf)
//   sub                 : 0 = a + b + c_in, 1 = a - b - c_in
//   c_out               : carry out (subtract: 1 = no borrow)
//   ovf                 : signed overflow
module pipelined_rca_addsub
    import pipelined_rca_addsub_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned STAGES = DefStages
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);
    localparam int unsigned Last  = (STAGES == 0) ? 0 : STAGES - 1;
    localparam int unsigned Depth = (STAGES == 0) ? 1 : STAGES;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_rca_addsub: STAGES must be >= 1 and divide WIDTH");
    end

    // Per-stage state: partial sum, chunk carry, carry into top bit, pending operands.
    logic [WIDTH-1:0] s_q [Depth];
    logic [WIDTH-1:0] s_d [Depth];
    logic [WIDTH-1:0] a_q [Depth];
    logic [WIDTH-1:0] a_d [Depth];
    logic [WIDTH-1:0] b_q [Depth];
    logic [WIDTH-1:0] b_d [Depth];
    logic             c_q [Depth];
    logic             c_d [Depth];
    logic             m_q [Depth];
    logic             m_d [Depth];
    logic             v_q [Depth];
    logic             v_d [Depth];

    logic [CHUNK-1:0] ca   [Depth];
    logic [CHUNK-1:0] cb   [Depth];
    logic             ci   [Depth];
    logic [CHUNK-1:0] cs   [Depth];
    logic             cco  [Depth];
    logic             cmsb [Depth];

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Whole pipeline moves in lock-step; a stalled output freezes every stage.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv & ~rst;

    assign b_eff   = sub ? ~b : b;
    assign cin_eff = c_in ^ sub;

    for (genvar k = 0; k < int'(Depth); k++) begin : g_chunk
        rca_chunk #(
            .W (CHUNK)
        ) u_chunk (
            .a_i     (ca[k]),
            .b_i     (cb[k]),
            .cin_i   (ci[k]),
            .s_o     (cs[k]),
            .cout_o  (cco[k]),
            .c_msb_o (cmsb[k])
        );
    end

    always_comb begin
        for (int k = 0; k < int'(Depth); k++) begin
            ca[k]  = '0;
            cb[k]  = '0;
            ci[k]  = 1'b0;
            s_d[k] = '0;
            a_d[k] = '0;
            b_d[k] = '0;
            c_d[k] = 1'b0;
            m_d[k] = 1'b0;
            v_d[k] = 1'b0;
        end

        // Stage 0 works straight from the ports.
        ca[0]              = a[CHUNK-1:0];
        cb[0]              = b_eff[CHUNK-1:0];
        ci[0]              = cin_eff;
        s_d[0][CHUNK-1:0]  = cs[0];
        a_d[0]             = a;
        b_d[0]             = b_eff;
        c_d[0]             = cco[0];
        m_d[0]             = cmsb[0];
        v_d[0]             = in_valid & in_ready;

        // Stage k adds slice k of the operands carried forward from stage k-1.
        for (int k = 1; k < int'(Depth); k++) begin
            ca[k]                  = a_q[k-1][k*CHUNK +: CHUNK];
            cb[k]                  = b_q[k-1][k*CHUNK +: CHUNK];
            ci[k]                  = c_q[k-1];
            s_d[k]                 = s_q[k-1];
            s_d[k][k*CHUNK +: CHUNK] = cs[k];
            a_d[k]                 = a_q[k-1];
            b_d[k]                 = b_q[k-1];
            c_d[k]                 = cco[k];
            m_d[k]                 = cmsb[k];
            v_d[k]                 = v_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(Depth); k++) begin
                s_q[k] <= '0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                c_q[k] <= 1'b0;
                m_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < int'(Depth); k++) begin
                s_q[k] <= s_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                c_q[k] <= c_d[k];
                m_q[k] <= m_d[k];
                v_q[k] <= v_d[k];
            end
        end
    end

    assign out_valid = v_q[Last];
    assign s         = s_q[Last];
    assign c_out     = c_q[Last];
    assign ovf       = m_q[Last] ^ c_q[Last];

endmodule

// File: tb/tb_pipelined_rca_addsub.sv
// Directed self-checking bench for pipelined_rca_addsub (32/4 and 8/1 configurations).
module tb_pipelined_rca_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf;
    logic [31:0] a, b, s;

    logic        in_valid8, in_ready8, out_valid8, c_out8, ovf8;
    logic [7:0]  a8, b8, s8;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipelined_rca_addsub #(
        .WIDTH  (32),
        .STAGES (4)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    pipelined_rca_addsub #(
        .WIDTH  (8),
        .STAGES (1)
    ) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .c_in      (1'b0),
        .sub       (1'b0),
        .out_valid (out_valid8),
        .out_ready (1'b1),
        .s         (s8),
        .c_out     (c_out8),
        .ovf       (ovf8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Golden model: {ovf, c_out, s}. Overflow from operand/result signs.
    function automatic logic [33:0] model(input logic [31:0] oa, input logic [31:0] ob,
                                          input logic ocin, input logic osub);
        logic [31:0] be;
        logic [32:0] sum;
        logic        v;
        be  = osub ? ~ob : ob;
        sum = {1'b0, oa} + {1'b0, be} + {32'd0, ocin ^ osub};
        v   = (oa[31] == be[31]) && (sum[31] != oa[31]);
        return {v, sum};
    endfunction

    task automatic drive(input logic v, input logic [31:0] da, input logic [31:0] db,
                         input logic dcin, input logic dsub);
        in_valid = v;
        a        = da;
        b        = db;
        c_in     = dcin;
        sub      = dsub;
    endtask

    // Single op with an idle pipeline: result must appear exactly STAGES edges later.
    task automatic single_op(input string tag, input logic [31:0] da, input logic [31:0] db,
                             input logic dcin, input logic dsub, input logic [31:0] es,
                             input logic ec, input logic eo);
        @(posedge clk); #1;
        drive(1'b1, da, db, dcin, dsub);
        @(posedge clk); #1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 check({tag, "_early"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_s"}, 64'(s), 64'(es));
        check({tag, "_cout"}, 64'(c_out), 64'(ec));
        check({tag, "_ovf"}, 64'(ovf), 64'(eo));
    endtask

    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic        vc [8];
    logic        vs [8];

    initial begin
        logic [33:0] exp_q [$];
        logic [33:0] e;
        logic [31:0] s_prev;
        logic        c_prev, o_prev, stall_prev;
        int          idx, got, cyc, seen;

        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        out_ready = 1'b1;
        in_valid8 = 1'b0;
        a8 = '0;
        b8 = '0;

        // Test 1: reset for 3 cycles, then release
        repeat (3) @(posedge clk);
        #1 check("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("rel_out_valid", 64'(out_valid), 64'd0);
        check("rel_s", 64'(s), 64'd0);
        check("rel_cout", 64'(c_out), 64'd0);
        check("rel_ovf", 64'(ovf), 64'd0);
        check("rel_in_ready", 64'(in_ready), 64'd1);

        // Tests 2-4: directed arithmetic with hand-computed results
        single_op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        single_op("povf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        single_op("povf_ci", 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h8000_0001, 1'b0,
                  1'b1);
        single_op("sub", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        single_op("sub_bi", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0,
                  1'b0);

        // Test 5: 8 back-to-back ops, out_ready low in cycles 3..7
        va = '{32'h1234_5678, 32'h8000_0000, 32'h0000_0000, 32'hDEAD_BEEF,
               32'h7FFF_FFFF, 32'h0F0F_0F0F, 32'hFFFF_0000, 32'h0000_FFFF};
        vb = '{32'h1111_1111, 32'h0000_0001, 32'h0000_0001, 32'hCAFE_F00D,
               32'h7FFF_FFFF, 32'hF0F0_F0F0, 32'h0001_0000, 32'h0000_0001};
        vc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vs = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        idx = 0;
        got = 0;
        cyc = 0;
        stall_prev = 1'b0;
        s_prev = '0;
        c_prev = 1'b0;
        o_prev = 1'b0;
        while (got < 8 && cyc < 60) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= 3 && cyc <= 7);
            if (idx < 8) drive(1'b1, va[idx], vb[idx], vc[idx], vs[idx]);
            else         drive(1'b0, '0, '0, 1'b0, 1'b0);
            #1;
            if (stall_prev) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_s", 64'(s), 64'(s_prev));
                check("hold_cout", 64'(c_out), 64'(c_prev));
                check("hold_ovf", 64'(ovf), 64'(o_prev));
            end
            if (out_valid && !out_ready) check("stall_in_ready", 64'(in_ready), 64'd0);
            if (in_valid && in_ready) begin
                exp_q.push_back(model(va[idx], vb[idx], vc[idx], vs[idx]));
                idx++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("b2b_spurious", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("b2b_s%0d", got), 64'(s), 64'(e[31:0]));
                    check($sformatf("b2b_c%0d", got), 64'(c_out), 64'(e[32]));
                    check($sformatf("b2b_o%0d", got), 64'(ovf), 64'(e[33]));
                end
                got++;
            end
            stall_prev = out_valid && !out_ready;
            s_prev = s;
            c_prev = c_out;
            o_prev = ovf;
            cyc++;
        end
        check("b2b_count", 64'(got), 64'd8);
        @(posedge clk); #1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        out_ready = 1'b1;

        // Test 6: one-cycle reset with 3 ops in flight
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive(1'b1, va[i], vb[i], vc[i], vs[i]);
        end
        @(posedge clk); #1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        #1 check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_s", 64'(s), 64'd0);
        check("mid_rst_in_ready1", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("mid_rst_stale", 64'(seen), 64'd0);

        // Test 7: 8-bit, single-stage adder, latency 1
        @(posedge clk); #1;
        in_valid8 = 1'b1;
        a8 = 8'h80;
        b8 = 8'h80;
        #1 check("w8_in_ready", 64'(in_ready8), 64'd1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        check("w8_valid", 64'(out_valid8), 64'd1);
        check("w8_s", 64'(s8), 64'h00);
        check("w8_cout", 64'(c_out8), 64'd1);
        check("w8_ovf", 64'(ovf8), 64'd1);
        @(posedge clk); #1;
        check("w8_drain", 64'(out_valid8), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
